// File: rtl/usb_reg_bridge.sv
// Bridge from asynchronous SAM3U external-bus strobes onto the internal reg_* bus.
// Optional protocol-error detection is enabled by defining USB_REG_PROTO_ERR_EN.
module usb_reg_bridge #(
   parameter int unsigned pDATA_WIDTH   = 8,
   parameter int unsigned pADDR_WIDTH   = 8,
   parameter int unsigned pBYTECNT_SIZE = 7,
   parameter int unsigned pRD_LATENCY   = 1,
   parameter int unsigned pDRIVE_HOLD   = 2
) (
   input  logic                     clk_usb,
   input  logic                     reset,
   input  logic [pDATA_WIDTH-1:0]   cwusb_din,
   output logic [pDATA_WIDTH-1:0]   cwusb_dout,
   output logic                     cwusb_isout,
   input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
   input  logic                     cwusb_rdn,
   input  logic                     cwusb_wrn,
   input  logic                     cwusb_cen,
   input  logic                     I_drive_data,
   output logic [pADDR_WIDTH-1:0]   reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic [pDATA_WIDTH-1:0]   reg_datao,
   input  logic [pDATA_WIDTH-1:0]   reg_datai,
   output logic                     reg_read,
   output logic                     reg_write,
   output logic                     reg_addrvalid,
   output logic                     proto_err,
   input  logic                     proto_err_clr
);

   localparam int unsigned LAT_W  = 3;
   localparam int unsigned HOLD_W = 3;

`ifdef USB_REG_PROTO_ERR_EN
   localparam bit PROTO_EN = 1'b1;
`else
   localparam bit PROTO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE,
      WR_ACT,
      WR_DONE
   } state_t;

   state_t                   state;
   logic [1:0]               rdn_sync;
   logic [1:0]               wrn_sync;
   logic [1:0]               cen_sync;
   logic                     rd;
   logic                     wr;
   logic [LAT_W-1:0]         lat_cnt;
   logic [HOLD_W-1:0]        hold_cnt;
   logic                     rd_active;
   logic [pDATA_WIDTH-1:0]   din_q;

   // Two-flop synchronisers; idle (deasserted) value is 1.
   always_ff @(posedge clk_usb or posedge reset) begin
      if (reset) begin
         rdn_sync <= 2'b11;
         wrn_sync <= 2'b11;
         cen_sync <= 2'b11;
      end else begin
         rdn_sync <= {rdn_sync[0], cwusb_rdn};
         wrn_sync <= {wrn_sync[0], cwusb_wrn};
         cen_sync <= {cen_sync[0], cwusb_cen};
      end
   end

   assign rd = ~rdn_sync[1] & ~cen_sync[1];
   assign wr = ~wrn_sync[1] & ~cen_sync[1];

   // Access FSM; reg_read/reg_write default low so they pulse for one cycle.
   always_ff @(posedge clk_usb or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cwusb_dout    <= '0;
         reg_address   <= '0;
         reg_bytecnt   <= '0;
         reg_datao     <= '0;
         reg_read      <= 1'b0;
         reg_write     <= 1'b0;
         reg_addrvalid <= 1'b0;
         rd_active     <= 1'b0;
         lat_cnt       <= '0;
         din_q         <= '0;
      end else begin
         reg_read  <= 1'b0;
         reg_write <= 1'b0;
         case (state)
            IDLE: begin
               // With error detection on, a simultaneous rd/wr starts nothing.
               if (rd && !(PROTO_EN && wr)) begin
                  state         <= RD_WAIT;
                  reg_read      <= 1'b1;
                  reg_addrvalid <= 1'b1;
                  rd_active     <= 1'b1;
                  lat_cnt       <= '0;
                  reg_address   <= cwusb_addr;
                  if (cwusb_addr != reg_address) reg_bytecnt <= '0;
               end else if (wr && !rd) begin
                  state         <= WR_ACT;
                  reg_addrvalid <= 1'b1;
                  reg_address   <= cwusb_addr;
                  if (cwusb_addr != reg_address) reg_bytecnt <= '0;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == LAT_W'(pRD_LATENCY)) begin
                  cwusb_dout <= reg_datai;
                  state      <= RD_DRIVE;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            RD_DRIVE: begin
               if (!rd) begin
                  state         <= IDLE;
                  reg_addrvalid <= 1'b0;
                  rd_active     <= 1'b0;
                  reg_bytecnt   <= reg_bytecnt + pBYTECNT_SIZE'(1);
               end
            end
            WR_ACT: begin
               if (wr) begin
                  din_q <= cwusb_din;
               end else begin
                  reg_datao <= din_q;
                  reg_write <= 1'b1;
                  state     <= WR_DONE;
               end
            end
            WR_DONE: begin
               state         <= IDLE;
               reg_addrvalid <= 1'b0;
               reg_bytecnt   <= reg_bytecnt + pBYTECNT_SIZE'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Keeps the bus driven for pDRIVE_HOLD cycles after the read states end.
   always_ff @(posedge clk_usb or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (rd_active) begin
         hold_cnt <= HOLD_W'(pDRIVE_HOLD);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 3'd1;
      end
   end

   assign cwusb_isout = rd_active | (hold_cnt != '0) | I_drive_data;

`ifdef USB_REG_PROTO_ERR_EN
   logic err_set;

   always_comb begin
      err_set = 1'b0;
      case (state)
         IDLE:              err_set = rd & wr;
         RD_WAIT, RD_DRIVE: err_set = wr;
         WR_ACT, WR_DONE:   err_set = rd;
         default:           err_set = 1'b0;
      endcase
   end

   // Sticky flag; a new error in the clear cycle keeps it set.
   always_ff @(posedge clk_usb or posedge reset) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if (err_set) begin
         proto_err <= 1'b1;
      end else if (proto_err_clr) begin
         proto_err <= 1'b0;
      end
   end
`else
   logic unused_proto_err_clr;
   assign unused_proto_err_clr = proto_err_clr;
   assign proto_err = 1'b0;
`endif

endmodule
